// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered ALU stage with a valid/ready handshake on both sides.
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready      request handshake; alu_ctrl, src_a, src_b sampled on accept
//   out_valid/out_ready    result handshake; result, zero, illegal held until retired
// Optional feature: define ALU_EXEC_MULT_EN to add code 1000, an iterative
// shift-add unsigned multiply (one bit per cycle, WIDTH cycles in BUSY).
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FULL = 2'd1;
`ifdef ALU_EXEC_MULT_EN
    localparam logic [1:0] BUSY = 2'd2;
    localparam int         CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic             accept;
    logic             is_mul;

`ifdef ALU_EXEC_MULT_EN
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] acc_step;
    logic [CW-1:0]    cnt_q, cnt_d;
    assign is_mul   = (alu_ctrl == 4'b1000);
    assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
`else
    assign is_mul = 1'b0;
`endif

    // FULL only accepts when the held result is retired in the same edge.
    assign in_ready  = (state_q == IDLE) || (state_q == FULL && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == FULL);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (alu_ctrl)
            4'b0000: alu_res = src_a & src_b;
            4'b0001: alu_res = src_a | src_b;
            4'b0010: alu_res = src_a + src_b;
            4'b0110: alu_res = src_a - src_b;
            4'b0111: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'b1100: alu_res = ~(src_a | src_b);
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        if (accept && !is_mul) begin
            state_d   = FULL;
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = alu_ill;
        end else if (state_q == FULL && out_ready) begin
            state_d = IDLE;
        end
`ifdef ALU_EXEC_MULT_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (accept && is_mul) begin
            state_d  = BUSY;
            mcand_d  = src_a;
            mplier_d = src_b;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (state_q == BUSY) begin
            // One multiplier bit per cycle; the last step writes the product straight out.
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = acc_step;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                state_d   = FULL;
                result_d  = acc_step;
                zero_d    = (acc_step == '0);
                illegal_d = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
`ifdef ALU_EXEC_MULT_EN
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
`ifdef ALU_EXEC_MULT_EN
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
`endif
        end
    end
endmodule
